// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the memory-mapped peripheral window: register offsets,
// TCON bit positions and the default base address.
package peripheral_bus_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

    // Byte offsets within the 32-byte window, with addr[1:0] forced to zero.
    localparam logic [4:0] TH_OFF      = 5'h00;
    localparam logic [4:0] TL_OFF      = 5'h04;
    localparam logic [4:0] TCON_OFF    = 5'h08;
    localparam logic [4:0] LED_OFF     = 5'h0C;
    localparam logic [4:0] SWITCH_OFF  = 5'h10;
    localparam logic [4:0] DIGI_OFF    = 5'h14;
    localparam logic [4:0] SYSTICK_OFF = 5'h18;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_ST = 2;

endpackage

// File: rtl/periph_timer.sv
// Interval timer: TH reload, TL up-counter with optional prescaler, and TCON
// control/status. Overflow reloads TL from TH and latches a sticky status.
module periph_timer
    import peripheral_bus_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irqout
);

    logic [31:0] th_q, tl_q, presc_q;
    logic [2:0]  tcon_q;
    logic        tick, ovf;

    assign tick = tcon_q[TCON_EN] && (presc_q == 32'(TICK_DIV - 1));
    // A TL write in the overflow cycle cancels the whole overflow event.
    assign ovf  = tick && (tl_q == 32'hFFFF_FFFF) && !tl_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q    <= '0;
            tl_q    <= '0;
            tcon_q  <= '0;
            presc_q <= '0;
        end else begin
            if (!tcon_q[TCON_EN] || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 32'd1;
            end

            if (th_we) begin
                th_q <= wdata;
            end

            if (tl_we) begin
                tl_q <= wdata;
            end else if (ovf) begin
                tl_q <= th_q;
            end else if (tick) begin
                tl_q <= tl_q + 32'd1;
            end

            if (tcon_we) begin
                tcon_q <= wdata[2:0];
            end else if (ovf) begin
                tcon_q[TCON_ST] <= tcon_q[TCON_ST] | tcon_q[TCON_IE];
            end
        end
    end

    assign th     = th_q;
    assign tl     = tl_q;
    assign tcon   = tcon_q;
    assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_ST];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped I/O block: window decode, LED/7-seg outputs, synchronised
// switches, free-running systick and the interval timer.
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    logic        hit, we;
    logic [4:0]  offs;
    logic [7:0]  led_q, sw_meta_q, sw_sync_q;
    logic [11:0] digi_q;
    logic [31:0] systick_q, th, tl;
    logic [2:0]  tcon;
    logic        unused_addr;

    assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
    assign offs        = {addr[4:2], 2'b00};
    assign we          = wr && hit;
    assign unused_addr = ^addr[1:0];

    periph_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (we && (offs == TH_OFF)),
        .tl_we   (we && (offs == TL_OFF)),
        .tcon_we (we && (offs == TCON_OFF)),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irqout  (irqout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            digi_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            systick_q <= '0;
        end else begin
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            systick_q <= systick_q + 32'd1;
            if (we && (offs == LED_OFF)) begin
                led_q <= wdata[7:0];
            end
            if (we && (offs == DIGI_OFF)) begin
                digi_q <= wdata[11:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (offs)
                TH_OFF:      rdata = th;
                TL_OFF:      rdata = tl;
                TCON_OFF:    rdata = {29'd0, tcon};
                LED_OFF:     rdata = {24'd0, led_q};
                SWITCH_OFF:  rdata = {24'd0, sw_sync_q};
                DIGI_OFF:    rdata = {20'd0, digi_q};
                SYSTICK_OFF: rdata = systick_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Randomised and directed bench for peripheral_bus with a register-level model
// and a scoreboard drained by an independent monitor.
module tb_peripheral_bus;

    localparam logic [31:0] B    = 32'h4000_0000;
    localparam int unsigned TDIV = 1;

    logic        clk, reset, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  switch, led;
    logic [11:0] digi;
    logic        irqout;

    peripheral_bus #(
        .BASE_ADDR (B),
        .TICK_DIV  (TDIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .switch (switch),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {KRdata, KLed, KDigi, KIrq} kind_e;
    typedef struct {
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, register-level view.
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led, m_sw1, m_sw2;
    logic [11:0] m_digi;
    int unsigned m_presc;

    function automatic void model_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
        m_sw1 = 0; m_sw2 = 0; m_systick = 0; m_presc = 0;
    endfunction

    function automatic logic [31:0] mread(logic [31:0] a);
        if (a[31:5] != B[31:5]) return 32'd0;
        case (a[4:2])
            3'd0: return m_th;
            3'd1: return m_tl;
            3'd2: return {29'd0, m_tcon};
            3'd3: return {24'd0, m_led};
            3'd4: return {24'd0, m_sw2};
            3'd5: return {20'd0, m_digi};
            3'd6: return m_systick;
            default: return 32'd0;
        endcase
    endfunction

    // Applies one rising edge to the model using the inputs the DUT saw.
    function automatic void model_edge();
        logic        hit, tick, tl_wr;
        logic [31:0] old_th;
        if (reset) return;
        hit    = (addr[31:5] == B[31:5]);
        tl_wr  = wr && hit && (addr[4:2] == 3'd1);
        old_th = m_th;
        tick   = 1'b0;
        if (m_tcon[0]) begin
            if (m_presc == TDIV - 1) begin
                tick    = 1'b1;
                m_presc = 0;
            end else begin
                m_presc = m_presc + 1;
            end
        end else begin
            m_presc = 0;
        end
        if (tick && !tl_wr) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                m_tl      = old_th;
                m_tcon[2] = m_tcon[2] | m_tcon[1];
            end else begin
                m_tl = m_tl + 1;
            end
        end
        m_systick = m_systick + 1;
        m_sw2     = m_sw1;
        m_sw1     = switch;
        if (wr && hit) begin
            case (addr[4:2])
                3'd0: m_th   = wdata;
                3'd1: m_tl   = wdata;
                3'd2: m_tcon = wdata[2:0];
                3'd3: m_led  = wdata[7:0];
                3'd5: m_digi = wdata[11:0];
                default: ;
            endcase
        end
    endfunction

    task automatic chk(input kind_e k, input string n, input logic [31:0] v);
        exp_t e;
        e.kind = k; e.name = n; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic issue(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        chk(KRdata, "rdata_model", r ? mread(a) : 32'd0);
        chk(KLed, "led_model", {24'd0, m_led});
        chk(KDigi, "digi_model", {20'd0, m_digi});
        chk(KIrq, "irq_model", {31'd0, m_tcon[1] & m_tcon[2]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic op(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
        issue(r, w, a, d);
        step();
    endtask

    // Monitor: compares every pending expectation against the live outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                KRdata:  act = rdata;
                KLed:    act = {24'd0, led};
                KDigi:   act = {20'd0, digi};
                default: act = {31'd0, irqout};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        reset = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0; switch = 0;
        model_reset();
        issue(1, 0, B + 32'h04, 0);
        chk(KRdata, "reset_tl", 32'd0);
        chk(KIrq, "reset_irq", 32'd0);
        step();
        step();
        reset = 1'b0;

        // LED / DIGI write and readback
        op(0, 1, B + 32'h0C, 32'h0000_01A5);
        issue(1, 0, B + 32'h0C, 0);
        chk(KLed, "led_val", 32'hA5);
        chk(KRdata, "led_rd", 32'hA5);
        step();
        op(0, 1, B + 32'h14, 32'hFFFF_FFFF);
        issue(1, 0, B + 32'h14, 0);
        chk(KDigi, "digi_val", 32'hFFF);
        chk(KRdata, "digi_rd", 32'h0000_0FFF);
        step();

        // Switch through the synchroniser, RO/reserved/out-of-window accesses
        switch = 8'h3C;
        op(0, 0, 0, 0);
        op(0, 0, 0, 0);
        op(0, 1, B + 32'h10, 32'hFF);
        op(0, 1, B + 32'h18, 32'h0);
        op(0, 1, B + 32'h2C, 32'h77);
        issue(1, 0, B + 32'h10, 0);
        chk(KRdata, "switch_rd", 32'h3C);
        chk(KLed, "led_after_oow_wr", 32'hA5);
        step();
        issue(1, 0, B + 32'h1C, 0);
        chk(KRdata, "reserved_rd", 32'd0);
        step();
        issue(1, 0, 32'h1000_0000, 0);
        chk(KRdata, "outside_rd", 32'd0);
        step();
        op(1, 0, B + 32'h20, 0);
        op(1, 0, B + 32'h18, 0);

        // Overflow with reload, sticky status, TCON write colliding with overflow
        op(0, 1, B + 32'h00, 32'hFFFF_FFFD);
        op(0, 1, B + 32'h04, 32'hFFFF_FFFE);
        op(0, 1, B + 32'h08, 32'h3);
        issue(1, 0, B + 32'h04, 0); chk(KRdata, "tl_start", 32'hFFFF_FFFE); step();
        issue(1, 0, B + 32'h04, 0); chk(KRdata, "tl_max", 32'hFFFF_FFFF); step();
        issue(1, 0, B + 32'h04, 0); chk(KRdata, "tl_reload", 32'hFFFF_FFFD);
        chk(KIrq, "irq_set", 32'd1); step();
        issue(1, 0, B + 32'h08, 0); chk(KRdata, "tcon_sticky", 32'h7); step();
        issue(0, 1, B + 32'h08, 32'h3); chk(KIrq, "irq_held", 32'd1); step();
        issue(1, 0, B + 32'h08, 0); chk(KRdata, "tcon_write_wins", 32'h3);
        chk(KIrq, "irq_cleared", 32'd0); step();
        issue(1, 0, B + 32'h04, 0); chk(KRdata, "tl_counting", 32'hFFFF_FFFE); step();

        // TL write colliding with overflow
        op(0, 1, B + 32'h08, 32'h0);
        op(0, 1, B + 32'h04, 32'hFFFF_FFFE);
        op(0, 1, B + 32'h08, 32'h3);
        op(0, 0, 0, 0);
        issue(0, 1, B + 32'h04, 32'h0000_1234); step();
        issue(1, 0, B + 32'h04, 0); chk(KRdata, "tl_write_wins", 32'h1234); step();
        issue(1, 0, B + 32'h08, 0); chk(KRdata, "tcon_no_status", 32'h3); step();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, d;
            int unsigned off;
            off = $urandom_range(0, 7);
            a   = B + off * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            d = $urandom;
            if (off < 2 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            if (off == 2) d = (($urandom_range(0, 3) != 0) ? 32'h3 : $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
            op(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d);
        end

        // Asynchronous reset mid-run
        op(0, 1, B + 32'h0C, 32'h55);
        op(0, 1, B + 32'h14, 32'h123);
        op(0, 1, B + 32'h08, 32'h3);
        op(0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        issue(1, 0, B + 32'h08, 0);
        chk(KRdata, "rst_tcon", 32'd0);
        chk(KIrq, "rst_irq", 32'd0);
        chk(KLed, "rst_led", 32'd0);
        chk(KDigi, "rst_digi", 32'd0);
        step();
        issue(1, 0, B + 32'h18, 0); chk(KRdata, "rst_systick", 32'd0); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) op(1, 0, B + 32'h04, 0);
        op(1, 0, B + 32'h18, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
